// File: rtl/snn_fp_pkg.sv
// Shared single-precision field constants, the FP32 view struct and the sweep
// state encoding used by the neuron-core potential blocks.
package snn_fp_pkg;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_W   = 23;

  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_e;

  // Signed zero keeping the sign of the original value.
  function automatic fp32_t fp32_signed_zero(input logic sign);
    fp32_t z;
    z.sign = sign;
    z.exp  = 8'd0;
    z.mant = {MANT_W{1'b0}};
    return z;
  endfunction

endpackage

// File: rtl/fp32_exp_decay.sv
// Combinational multiply-by-2^-k on an FP32 value by exponent decrement.
// Inf/NaN pass through, zeros/denormals flush to signed zero, and results
// that would leave the normal range flush to signed zero with underflow_o set.
module fp32_exp_decay
  import snn_fp_pkg::*;
#(
  parameter int K_W = 3
) (
  input  logic [31:0]    value_i,
  input  logic [K_W-1:0] k_i,
  output logic [31:0]    result_o,
  output logic           underflow_o
);

  logic              sign_s;
  logic [7:0]        exp_s;
  logic [MANT_W-1:0] mant_s;
  logic [7:0]        k_ext_s;
  fp32_t             res_s;

  // Classify the input and apply the exponent decrement.
  always_comb begin
    sign_s      = value_i[SIGN_BIT];
    exp_s       = value_i[EXP_MSB:EXP_LSB];
    mant_s      = value_i[MANT_W-1:0];
    k_ext_s     = 8'(k_i);
    res_s       = value_i;
    underflow_o = 1'b0;
    if (exp_s == EXP_SPECIAL) begin
      res_s = value_i;
    end else if (exp_s == 8'd0) begin
      res_s = fp32_signed_zero(sign_s);
    end else if (k_ext_s == 8'd0) begin
      res_s = value_i;
    end else if (exp_s <= k_ext_s) begin
      res_s       = fp32_signed_zero(sign_s);
      underflow_o = 1'b1;
    end else begin
      res_s.sign = sign_s;
      res_s.exp  = exp_s - k_ext_s;
      res_s.mant = mant_s;
    end
    result_o = res_s;
  end

endmodule

// File: rtl/potential_decay_array.sv
// Sweeps NUM_NEURONS FP32 membrane potentials from neuron-state memory, decays
// each by 2^-decay_shift and streams results through a 2-entry output FIFO.
// Optional macro DECAY_UNDERFLOW_STAT_EN adds underflow_count, the number of
// results flushed by exponent underflow during the current sweep.
module potential_decay_array
  import snn_fp_pkg::*;
#(
  parameter  int NUM_NEURONS = 16,
  parameter  int SHIFT_W     = 3,
  localparam int ADDR_W      = $clog2(NUM_NEURONS)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic [SHIFT_W-1:0] decay_shift,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [31:0]        rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [31:0]        out_potential,
  output logic               busy,
  output logic               done
`ifdef DECAY_UNDERFLOW_STAT_EN
  ,
  output logic [ADDR_W:0]    underflow_count
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);

  sweep_state_e       state_q, state_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               inflight_q;
  logic [ADDR_W-1:0]  inflight_addr_q;
  logic [31:0]        fifo_data_q [2];
  logic [ADDR_W-1:0]  fifo_addr_q [2];
  logic               head_q, tail_q;
  logic [1:0]         count_q;

  logic               pop_s, push_s, rd_en_s, start_acc_s;
  logic [31:0]        decayed_s;
  logic               underflow_s;

  fp32_exp_decay #(.K_W(SHIFT_W)) u_decay (
    .value_i     (rd_data),
    .k_i         (shift_q),
    .result_o    (decayed_s),
    .underflow_o (underflow_s)
  );

  // Issue a read only if the FIFO can absorb it, counting data still in flight.
  always_comb begin
    pop_s   = (count_q != 2'd0) && out_ready;
    push_s  = inflight_q;
    rd_en_s = 1'b0;
    if (state_q == ST_SCAN) begin
      rd_en_s = (({1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s}) < 3'd2);
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Sweep sequencing: next state, latched shift and read pointer.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    rd_addr_d   = rd_addr_q;
    start_acc_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_SCAN;
          shift_d     = decay_shift;
          rd_addr_d   = '0;
          start_acc_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (rd_en_s && (rd_addr_q == LAST_ADDR)) begin
          state_d = ST_DRAIN;
        end else if (rd_en_s) begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end else begin
          state_d = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        if (pop_s && (fifo_addr_q[head_q] == LAST_ADDR)) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, shift and read-pointer registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Track the read whose data returns next cycle; reset drops it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      inflight_q      <= rd_en_s;
      inflight_addr_q <= rd_addr_q;
    end
  end

  // Two-entry output FIFO; returning data is decayed and pushed on arrival.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= 32'd0;
        fifo_addr_q[i] <= '0;
      end
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_data_q[tail_q] <= decayed_s;
        fifo_addr_q[tail_q] <= inflight_addr_q;
        tail_q              <= ~tail_q;
      end
      if (pop_s) begin
        head_q <= ~head_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef DECAY_UNDERFLOW_STAT_EN
  logic [ADDR_W:0] uf_count_q;

  // Count underflow flushes of the current sweep; cleared on a new start.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      uf_count_q <= '0;
    end else if (start_acc_s) begin
      uf_count_q <= '0;
    end else if (push_s && underflow_s) begin
      uf_count_q <= uf_count_q + (ADDR_W+1)'(1);
    end else begin
      uf_count_q <= uf_count_q;
    end
  end

  assign underflow_count = uf_count_q;
`else
  logic unused_stat_s;
  assign unused_stat_s = underflow_s ^ start_acc_s;
`endif

  assign rd_en         = rd_en_s;
  assign rd_addr       = rd_addr_q;
  assign out_valid     = (count_q != 2'd0);
  assign out_addr      = fifo_addr_q[head_q];
  assign out_potential = fifo_data_q[head_q];
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FINISH);

endmodule

// File: tb/tb_potential_decay_array.sv
// Self-checking bench for potential_decay_array: directed and random sweeps
// against a real-arithmetic reference model of the decay.
module tb_potential_decay_array;

  localparam int N  = 16;
  localparam int AW = 4;
  localparam int SW = 3;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          start;
  logic [SW-1:0] decay_shift;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [31:0]   out_potential;
  logic          busy;
  logic          done;
`ifdef DECAY_UNDERFLOW_STAT_EN
  logic [AW:0]   underflow_count;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mem   [N];
  logic [31:0] exp_v [N];
  logic [31:0] obs_v [N];
  int          exp_uf;

  potential_decay_array #(.NUM_NEURONS(N), .SHIFT_W(SW)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .start         (start),
    .decay_shift   (decay_shift),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_potential (out_potential),
    .busy          (busy),
    .done          (done)
`ifdef DECAY_UNDERFLOW_STAT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Neuron-state memory: data one cycle after rd_en, junk otherwise.
  always @(posedge CLK) begin
    rd_data <= rd_en ? mem[rd_addr] : $urandom();
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: value * 2^-k in real arithmetic, subnormal results flushed.
  function automatic logic [31:0] model_decay(input logic [31:0] v, input int k, output bit uf);
    int          e;
    int          de;
    real         mag;
    logic [63:0] d;
    logic [31:0] r;
    uf = 1'b0;
    e  = int'(v[30:23]);
    if (e == 255) return v;
    if (e == 0) return {v[31], 31'd0};
    mag = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    mag = mag / (2.0 ** k);
    if (mag < 2.0 ** (-126)) begin
      uf = 1'b1;
      return {v[31], 31'd0};
    end
    d  = $realtobits(mag);
    de = int'(d[62:52]) - 1023 + 127;
    r  = {v[31], de[7:0], d[51:29]};
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) begin
      logic [31:0] w;
      w = $urandom();
      case ($urandom_range(0, 3))
        0: mem[i] = w;
        1: mem[i] = {w[31], 8'($urandom_range(1, 9)), w[22:0]};
        2: mem[i] = {w[31], ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00, w[22:0]};
        default: mem[i] = {w[31], 8'($urandom_range(100, 150)), w[22:0]};
      endcase
    end
  endtask

  // One sweep: start, run with optional random backpressure, check each cycle.
  task automatic run_sweep(input int k, input bit jitter, input int abort_after);
    int          issued, popped, last_hs, dones;
    bit          stalled, hs, u;
    logic [31:0] prev_pot;
    logic [AW-1:0] prev_addr;
    issued = 0; popped = 0; last_hs = -100; dones = 0;
    stalled = 1'b0; prev_pot = 32'd0; prev_addr = '0;
    exp_uf = 0;
    for (int i = 0; i < N; i++) begin
      exp_v[i] = model_decay(mem[i], k, u);
      exp_uf  += int'(u);
      obs_v[i] = 32'hDEADBEEF;
    end
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge CLK);
      start       = (cyc == 0) || (jitter && cyc == 10);
      decay_shift = (cyc == 0) ? SW'(k) : SW'($urandom());
      if (!jitter) out_ready = 1'b1;
      else if (cyc >= 12 && cyc <= 16) out_ready = 1'b0;
      else out_ready = ($urandom_range(0, 3) != 0);
      #1;
      check32("busy", 32'(busy), 32'(cyc >= 1 && dones == 0));
      check32("done", 32'(done), 32'(popped == N && last_hs == cyc - 1));
      if (done) dones++;
      if (stalled) begin
        check32("stall_addr", 32'(out_addr), 32'(prev_addr));
        check32("stall_pot", out_potential, prev_pot);
        check32("stall_valid", 32'(out_valid), 32'd1);
      end
      if (rd_en) begin
        check32("rd_addr", 32'(rd_addr), 32'(issued));
        if (!jitter) check32("rd_cycle", 32'(cyc), 32'(issued + 1));
        issued++;
      end
      hs = out_valid && out_ready;
      if (hs) begin
        check32("out_addr", 32'(out_addr), 32'(popped));
        if (popped < N) begin
          check32("out_pot", out_potential, exp_v[popped]);
          obs_v[popped] = out_potential;
        end
        if (!jitter) check32("out_cycle", 32'(cyc), 32'(popped + 3));
        popped++;
        last_hs = cyc;
      end
      check32("no_overrun", 32'(issued - popped <= 2), 32'd1);
      stalled   = out_valid && !out_ready;
      prev_pot  = out_potential;
      prev_addr = out_addr;
      if (abort_after > 0 && popped == abort_after) break;
      if (dones > 0 && cyc >= last_hs + 3) break;
    end
    if (abort_after == 0) begin
      check32("done_count", 32'(dones), 32'd1);
      check32("popped", 32'(popped), 32'(N));
      check32("issued", 32'(issued), 32'(N));
`ifdef DECAY_UNDERFLOW_STAT_EN
      check32("uf_count", 32'(underflow_count), 32'(exp_uf));
`endif
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; decay_shift = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 32'd0;
    repeat (2) @(negedge CLK);
    #1;
    check32("rst_rd_en", 32'(rd_en), 32'd0);
    check32("rst_rd_addr", 32'(rd_addr), 32'd0);
    check32("rst_valid", 32'(out_valid), 32'd0);
    check32("rst_out_addr", 32'(out_addr), 32'd0);
    check32("rst_out_pot", out_potential, 32'd0);
    check32("rst_busy", 32'(busy), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
`ifdef DECAY_UNDERFLOW_STAT_EN
    check32("rst_uf", 32'(underflow_count), 32'd0);
`endif
    RESET = 1'b0;

    // Basic halving
    fill_random();
    mem[0] = 32'h3F800000;
    run_sweep(1, 1'b0, 0);
    check32("halve_1p0", obs_v[0], 32'h3F000000);

    // Negative value
    fill_random();
    mem[3] = 32'hC0C00000;
    run_sweep(2, 1'b0, 0);
    check32("neg_6p0", obs_v[3], 32'hBFC00000);

    // Underflow and denormal flush
    for (int i = 0; i < N; i++) mem[i] = 32'h40000000 | 32'(i);
    mem[0] = 32'h00800000;
    mem[1] = 32'h80800000;
    mem[2] = 32'h00000001;
    run_sweep(1, 1'b0, 0);
    check32("uf_pos", obs_v[0], 32'h00000000);
    check32("uf_neg", obs_v[1], 32'h80000000);
    check32("denorm", obs_v[2], 32'h00000000);
`ifdef DECAY_UNDERFLOW_STAT_EN
    check32("uf_count_dir", 32'(underflow_count), 32'd2);
`endif

    // Specials and zero shift
    fill_random();
    mem[0] = 32'h7F800000;
    mem[1] = 32'h7FC00000;
    mem[2] = 32'h40490FDB;
    run_sweep(0, 1'b0, 0);
    check32("inf", obs_v[0], 32'h7F800000);
    check32("nan", obs_v[1], 32'h7FC00000);
    check32("pi_k0", obs_v[2], 32'h40490FDB);

    // Backpressure with random ready and an ignored mid-sweep start
    fill_random();
    run_sweep(7, 1'b1, 0);
    fill_random();
    run_sweep(3, 1'b1, 0);

    // Reset mid-sweep, then a fresh sweep from address 0
    fill_random();
    run_sweep(3, 1'b0, 7);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    #1;
    check32("abort_valid", 32'(out_valid), 32'd0);
    check32("abort_busy", 32'(busy), 32'd0);
    check32("abort_done", 32'(done), 32'd0);
    check32("abort_rd_en", 32'(rd_en), 32'd0);
    RESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      #1;
      check32("abort_no_done", 32'(done), 32'd0);
      check32("abort_idle", 32'(busy), 32'd0);
    end
    fill_random();
    run_sweep(5, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
